// File: rtl/ram_sync_rw_clr.sv
// ---------------------------------------------------------------------------
// ram_sync_rw_clr
//   Single-port synchronous RAM with a registered read port and a hardware
//   clear sweep. After reset, or when clr is pulsed, the block spends DEPTH
//   cycles writing CLR_VALUE into every entry, one entry per cycle. User
//   requests are ignored while that happens.
//
// Ports
//   clock       rising-edge clock
//   reset_n     asynchronous active-low reset; starts a fresh sweep on release
//   addr        read/write address
//   din         write data
//   we          write enable (honoured only when not busy)
//   re          read enable  (honoured only when not busy)
//   clr         one-cycle request to start a clear sweep (beats we/re)
//   dout        registered read data; holds its value between reads
//   dout_valid  one-cycle pulse marking new data on dout
//   busy        high while the clear sweep runs
// ---------------------------------------------------------------------------
module ram_sync_rw_clr #(
    parameter int                 AWIDTH    = 3,
    parameter int                 DWIDTH    = 14,
    parameter int                 RDW_MODE  = 0,
    parameter logic [DWIDTH-1:0]  CLR_VALUE = '0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [AWIDTH-1:0] addr,
    input  logic [DWIDTH-1:0] din,
    input  logic              we,
    input  logic              re,
    input  logic              clr,
    output logic [DWIDTH-1:0] dout,
    output logic              dout_valid,
    output logic              busy
);

    localparam int DEPTH = 2 ** AWIDTH;
    localparam logic [AWIDTH-1:0] LAST = AWIDTH'(DEPTH - 1);

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    state_t              state, state_nxt;
    logic [AWIDTH-1:0]   clr_cnt, clr_cnt_nxt;

    logic                mem_we;
    logic [AWIDTH-1:0]   mem_waddr;
    logic [DWIDTH-1:0]   mem_wdata;
    logic                rd_acc;
    logic [DWIDTH-1:0]   rd_data;

    // No reset on the array: contents are only meaningful after a sweep.
    logic [DWIDTH-1:0]   mem [DEPTH];

    // Next state and the single write port's source. The sweep and user
    // writes share the port; the FSM state decides who owns it.
    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        mem_we      = 1'b0;
        mem_waddr   = addr;
        mem_wdata   = din;
        rd_acc      = 1'b0;
        case (state)
            CLEAR: begin
                mem_we      = 1'b1;
                mem_waddr   = clr_cnt;
                mem_wdata   = CLR_VALUE;
                // The counter wraps to 0 on the last entry, ready for the next sweep.
                clr_cnt_nxt = clr_cnt + AWIDTH'(1);
                if (clr_cnt == LAST)
                    state_nxt = IDLE;
            end
            IDLE: begin
                if (clr) begin
                    // clr wins over a same-cycle access; the access is dropped.
                    state_nxt   = CLEAR;
                    clr_cnt_nxt = '0;
                end else begin
                    mem_we = we;
                    rd_acc = re;
                end
            end
            default: state_nxt = CLEAR;
        endcase
    end

    // Same-address read-during-write: mem[addr] is sampled before this
    // edge's write lands, so it naturally gives old data. Write-through
    // mode forwards din instead.
    always_comb begin
        rd_data = mem[addr];
        if (RDW_MODE != 0 && we)
            rd_data = din;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= CLEAR;
            clr_cnt    <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            state      <= state_nxt;
            clr_cnt    <= clr_cnt_nxt;
            dout_valid <= rd_acc;
            if (rd_acc)
                dout <= rd_data;
        end
    end

    always_ff @(posedge clock) begin
        if (mem_we)
            mem[mem_waddr] <= mem_wdata;
    end

    assign busy = (state == CLEAR);

endmodule

// File: tb/tb_ram_sync_rw_clr.sv
// ---------------------------------------------------------------------------
// tb_ram_sync_rw_clr
//   Self-checking bench for ram_sync_rw_clr (AWIDTH=3, DWIDTH=14, RDW_MODE=0).
//   A table of vectors exercises normal access. Expected read data is pushed
//   to a scoreboard queue when a read is issued and popped when dout_valid
//   appears. Hand-written sequences cover the clear sweep and reset aborts.
// ---------------------------------------------------------------------------
module tb_ram_sync_rw_clr;

    localparam int          AW       = 3;
    localparam int          DW       = 14;
    localparam int          RDW      = 0;
    localparam logic [13:0] CLRV     = 14'h0;

    logic          clock;
    logic          reset_n;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic          we, re, clr;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          busy;

    ram_sync_rw_clr #(
        .AWIDTH   (AW),
        .DWIDTH   (DW),
        .RDW_MODE (RDW),
        .CLR_VALUE(CLRV)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .addr      (addr),
        .din       (din),
        .we        (we),
        .re        (re),
        .clr       (clr),
        .dout      (dout),
        .dout_valid(dout_valid),
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] din;
        logic          we;
        logic          re;
        logic          clr;
        logic          exp_busy;
        logic [DW-1:0] exp_dout;
    } vec_t;

    vec_t          tbl[$];
    logic [DW-1:0] sb[$];
    logic [DW-1:0] hold;
    int            checks = 0;
    int            errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then check outputs 1 time unit after the edge.
    // A read is accepted exactly when re is high and busy is expected low
    // both before and after (IDLE with no clr).
    task automatic step(input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic w, input logic r, input logic c,
                        input logic eb, input logic rd, input logic [DW-1:0] ed);
        logic [DW-1:0] e;
        addr = a; din = d; we = w; re = r; clr = c;
        if (rd) sb.push_back(ed);
        @(posedge clock); #1;
        chk("busy", busy, eb);
        chk("dout_valid", dout_valid, rd);
        if (dout_valid) begin
            if (sb.size() == 0) begin
                chk("scoreboard_empty", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("dout", dout, e);
                hold = e;
            end
        end else begin
            chk("dout_hold", dout, hold);
        end
        we = 1'b0; re = 1'b0; clr = 1'b0;
    endtask

    // Counts edges until busy drops; a sweep must take exactly 8.
    task automatic count_busy(input string nm);
        int n = 0;
        while (busy === 1'b1 && n < 20) begin
            @(posedge clock); #1;
            n++;
        end
        chk(nm, n, 8);
    endtask

    task automatic add(input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic w, input logic r, input logic [DW-1:0] ed);
        vec_t v;
        v.addr = a; v.din = d; v.we = w; v.re = r; v.clr = 1'b0;
        v.exp_busy = 1'b0; v.exp_dout = ed;
        tbl.push_back(v);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0;
        addr = '0; din = '0; we = 1'b0; re = 1'b0; clr = 1'b0;
        hold = '0;

        // Normal-access table: write/read, hold, read-during-write, streaming.
        add(3, 14'h1A5, 1, 0, 0);
        add(3, 14'h000, 0, 1, 14'h1A5);
        add(0, 14'h000, 0, 0, 0);            // dout holds with re low
        add(3, 14'h222, 1, 0, 0);            // a write does not move dout
        add(5, 14'h0F0, 1, 0, 0);
        add(5, 14'h3FF, 1, 1, (RDW != 0) ? 14'h3FF : 14'h0F0);
        add(5, 14'h000, 0, 1, 14'h3FF);
        for (int i = 0; i < 8; i++) add(AW'(i), DW'(i * 3), 1, 0, 0);
        for (int i = 0; i < 8; i++) add(AW'(i), 14'h0, 0, 1, DW'(i * 3));

        // Reset state and first sweep.
        repeat (3) @(posedge clock);
        #1;
        chk("reset_dout", dout, 0);
        chk("reset_dout_valid", dout_valid, 0);
        chk("reset_busy", busy, 1);
        @(negedge clock);
        reset_n = 1'b1;
        count_busy("busy_after_reset");
        for (int i = 0; i < 8; i++) step(AW'(i), 0, 0, 1, 0, 0, 1, CLRV);

        foreach (tbl[k])
            step(tbl[k].addr, tbl[k].din, tbl[k].we, tbl[k].re, tbl[k].clr,
                 tbl[k].exp_busy, tbl[k].re, tbl[k].exp_dout);

        // clr with a same-cycle write: write dropped, 8-cycle sweep, requests
        // during the sweep ignored (writes to entry 0 would survive if honoured).
        for (int i = 0; i < 8; i++) step(AW'(i), DW'(14'h2A0 + i), 1, 0, 0, 0, 0, 0);
        step(2, 14'h111, 1, 0, 1, 1, 0, 0);
        for (int i = 0; i < 7; i++) step(0, 14'h3FFF, 1, 1, 0, 1, 0, 0);
        step(0, 14'h3FFF, 1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(AW'(i), 0, 0, 1, 0, 0, 1, CLRV);

        // Reset in the middle of a sweep.
        step(1, 14'h055, 1, 0, 0, 0, 0, 0);
        step(1, 14'h000, 0, 1, 0, 0, 1, 14'h055);
        step(0, 0, 0, 0, 1, 1, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 1, 0, 0);
        reset_n = 1'b0;
        #2;
        chk("midsweep_rst_dout", dout, 0);
        chk("midsweep_rst_valid", dout_valid, 0);
        chk("midsweep_rst_busy", busy, 1);
        hold = '0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        count_busy("busy_after_midsweep_reset");
        step(1, 0, 0, 1, 0, 0, 1, CLRV);

        // Reset while a read result is on the outputs.
        step(1, 14'h077, 1, 0, 0, 0, 0, 0);
        step(1, 14'h000, 0, 1, 0, 0, 1, 14'h077);
        reset_n = 1'b0;
        #2;
        chk("midaccess_rst_dout", dout, 0);
        chk("midaccess_rst_valid", dout_valid, 0);
        hold = '0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        count_busy("busy_after_midaccess_reset");
        step(1, 0, 0, 1, 0, 0, 1, CLRV);

        chk("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
